// File: rtl/seg7_scan_ctrl_if.sv
// Load port of the 7-segment scan controller.
// A new display value is offered with valid/ready and carries one 4-bit code per digit.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one external hex decoder.
// Optional LEADING_ZERO_BLANK_EN macro suppresses leading zero digits.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       load,
  output logic [3:0]            dec_code,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done,
  output logic                  dbg_state
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV - 1 : BLANK_CYCLES - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS) + 1;
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [NUM_DIGITS-1:0] onehot;
  logic [DW-1:0]         active;
  logic [DW-1:0]         shadow;
  logic                  pending;
  logic                  xfer;
  logic                  hide_digit;

  // Handshake: load_ready = ~pending; a transfer happens on any cycle with
  // load_valid && load_ready and fills shadow. shadow moves to active only on
  // the last ON cycle of the last digit, so a frame never mixes two loads.
  assign load.load_ready = ~pending;
  assign xfer            = load.load_valid & ~pending;
  assign frame_done      = (state == ST_ON) && (cnt == ON_LAST) && (idx == IDX_LAST);
  assign dbg_state       = logic'(state);

  always_comb begin
    dec_code = 4'h0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        dec_code  = active[4*i +: 4];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_nz;

  // A digit is hidden when it and every more significant digit are zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (active[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    hide_digit = (idx != '0) && !upper_nz;
  end
`else
  assign hide_digit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    seg_nxt   = seg_out;
    en_nxt    = digit_en;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
          if (!hide_digit) begin
            seg_nxt = seg_in;
            en_nxt  = onehot;
          end
        end
      end
      ST_ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          seg_nxt   = 7'h7F;
          en_nxt    = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      seg_out  <= 7'h7F;
      digit_en <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      seg_out  <= seg_nxt;
      digit_en <= en_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (frame_done && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= load.load_data;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 2 blank + 4 on cycles per slot, 24-cycle frame.
// Honours LEADING_ZERO_BLANK_EN in its display model.
module tb_seg7_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dec_code;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic [3:0] digit_en;
  logic       frame_done;
  logic       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) lif ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .TICK_DIV    (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (lif),
    .dec_code  (dec_code),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .digit_en  (digit_en),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  // Active-low hex decoder, segment order gfedcba
  function automatic logic [6:0] hex7(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = hex7(dec_code);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic reset_check;
    chk("rst_seg", {9'h0, seg_out}, 16'h007F);
    chk("rst_en", {12'h0, digit_en}, 16'h0000);
    chk("rst_ready", {15'h0, lif.load_ready}, 16'h0001);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    chk("rst_dec_code", {12'h0, dec_code}, 16'h0000);
    chk("rst_state", {15'h0, dbg_state}, 16'h0000);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Expected outputs for the current cycle given the digits being displayed
  task automatic check_disp(input logic [15:0] shown, input logic exp_ready);
    int pos, slot, off;
    logic [3:0] d;
    logic [3:0] en_exp;
    logic       hide;
    pos    = cyc % 24;
    slot   = pos / 6;
    off    = pos % 6;
    d      = shown[4*slot +: 4];
    en_exp = 4'b0001 << slot;
    hide   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (shown >> (4*slot)) == 16'h0000) hide = 1'b1;
`endif
    if (off < 2) begin
      chk("blank_seg", {9'h0, seg_out}, 16'h007F);
      chk("blank_en", {12'h0, digit_en}, 16'h0000);
      chk("dec_code", {12'h0, dec_code}, {12'h0, d});
    end else begin
      chk("on_seg", {9'h0, seg_out}, hide ? 16'h007F : {9'h0, hex7(d)});
      chk("on_en", {12'h0, digit_en}, hide ? 16'h0000 : {12'h0, en_exp});
    end
    chk("frame_done", {15'h0, frame_done}, {15'h0, pos == 23});
    chk("ready", {15'h0, lif.load_ready}, {15'h0, exp_ready});
    chk("state", {15'h0, dbg_state}, {15'h0, off >= 2});
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = 16'h0000;
    reset          = 1'b1;
    tick;
    tick;
    reset_check;

    // Frame 0: zeros shown; 1234 accepted at cycle 5, ABCD offered while busy
    for (int c = 0; c < 24; c++) begin
      if (cyc == 5) begin lif.load_valid = 1'b1; lif.load_data = 16'h1234; end
      if (cyc == 6) lif.load_valid = 1'b0;
      if (cyc == 10) begin lif.load_valid = 1'b1; lif.load_data = 16'hABCD; end
      check_disp(16'h0000, cyc < 6);
      tick;
    end

    // Frame 1: 1234 shown; held ABCD accepted at cycle 24
    for (int c = 0; c < 24; c++) begin
      if (cyc == 25) lif.load_valid = 1'b0;
      check_disp(16'h1234, cyc == 24);
      tick;
    end

    // Frame 2: ABCD shown; 00F0 offered exactly on the boundary cycle
    for (int c = 0; c < 24; c++) begin
      if (cyc == 71) begin lif.load_valid = 1'b1; lif.load_data = 16'h00F0; end
      check_disp(16'hABCD, 1'b1);
      tick;
    end

    // Frame 3: boundary load is not bypassed
    for (int c = 0; c < 24; c++) begin
      if (cyc == 72) lif.load_valid = 1'b0;
      check_disp(16'hABCD, 1'b0);
      tick;
    end

    // Frame 4: 00F0 shown; 9999 pending when reset hits mid-ON of digit 2
    for (int c = 0; c < 16; c++) begin
      if (cyc == 97) begin lif.load_valid = 1'b1; lif.load_data = 16'h9999; end
      if (cyc == 98) lif.load_valid = 1'b0;
      if (cyc == 111) reset = 1'b1;
      check_disp(16'h00F0, cyc < 98);
      tick;
    end
    reset_check;

    // After reset: zeros, then 0050 loaded at cycle 0 is shown in the next frame
    for (int c = 0; c < 24; c++) begin
      if (cyc == 0) begin lif.load_valid = 1'b1; lif.load_data = 16'h0050; end
      if (cyc == 1) lif.load_valid = 1'b0;
      check_disp(16'h0000, cyc < 1);
      tick;
    end
    for (int c = 0; c < 24; c++) begin
      check_disp(16'h0050, 1'b1);
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
